multi_chan_comp: RTL and testbench

MULTI_CHAN_COMP -- requirements
Module: multi_chan_comp

---
 rtl/bus_comp_pkg.sv | 25 ++
 rtl/sat_cnt.sv | 23 ++
 rtl/multi_chan_comp.sv | 185 ++++++++++++++++++
 tb/tb_multi_chan_comp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_comp_pkg.sv
// Shared definitions for the multi-channel frame comparator.
//   - default parameter values for multi_chan_comp
//   - comparator FSM state encoding
//   - comp_status result encoding
package bus_comp_pkg;

    localparam int DEF_NCH     = 3;
    localparam int DEF_FRAME_W = 64;
    localparam int DEF_CRC_W   = 16;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMP   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STAT_MATCH    = 2'b00,
        STAT_FAIL     = 2'b01,
        STAT_MAJORITY = 2'b10,
        STAT_NONE     = 2'b11
    } status_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   inc : count up by one (ignored once the counter is all ones)
//   clr : synchronous clear, wins over a same-cycle inc
//   cnt : current count
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_chan_comp.sv
// Multi-channel redundant frame comparator with majority voting.
// A set of NCH frames is captured in IDLE, compared on the following cycle
// and the verdict is held in RESULT until the consumer takes it.
//   clk, rst        : clock, synchronous active-high reset
//   frame_in        : NCH frames, channel c at [c*FRAME_W +: FRAME_W]
//   crc_ok          : per-channel CRC-pass flags, sampled with frame_in
//   in_valid/ready  : input handshake (ready only in IDLE)
//   out_valid/ready : result handshake
//   comp_status     : 00 MATCH, 01 FAIL, 10 MAJORITY, 11 NONE
//   voted_data      : selected payload (CRC field stripped)
//   mismatch_map    : channels outvoted or CRC-failed
//   cnt_clr         : synchronous clear of both event counters
//   fail_cnt        : saturating count of FAIL results
//   degr_cnt        : saturating count of MAJORITY results
module multi_chan_comp
    import bus_comp_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int CRC_W   = DEF_CRC_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PAY_W   = FRAME_W - CRC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*FRAME_W-1:0] frame_in,
    input  logic [NCH-1:0]         crc_ok,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             comp_status,
    output logic [PAY_W-1:0]       voted_data,
    output logic [NCH-1:0]         mismatch_map,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       degr_cnt
);

    state_t             state_q, state_d;
    logic [PAY_W-1:0]   pay_q [NCH];
    logic [NCH-1:0]     crc_q;

    status_t            stat_d, stat_q;
    logic [PAY_W-1:0]   voted_d, voted_q;
    logic [NCH-1:0]     map_d, map_q;

    logic [2:0]         agree [NCH];
    logic               all_eq;
    logic               maj_found;
    logic [PAY_W-1:0]   maj_pay;

    logic               accept;
    logic               fail_inc, degr_inc, cnt_zero;
    logic               crc_field_unused;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESULT);
    assign accept    = in_valid && in_ready;

    // The CRC field of each frame is never compared.
    always_comb begin
        crc_field_unused = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            crc_field_unused = crc_field_unused ^ (^frame_in[c*FRAME_W +: CRC_W]);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_COMP;
            ST_COMP:   state_d = ST_RESULT;
            ST_RESULT: if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Payload / CRC-flag capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                pay_q[c] <= '0;
            end
        end else if (accept) begin
            crc_q <= crc_ok;
            for (int unsigned c = 0; c < NCH; c++) begin
                pay_q[c] <= frame_in[c*FRAME_W + CRC_W +: PAY_W];
            end
        end
    end

    // Voting: agree(c) counts CRC-ok channels equal to channel c (including c),
    // forced to zero when c itself failed CRC.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            agree[c] = '0;
            if (crc_q[c]) begin
                for (int unsigned j = 0; j < NCH; j++) begin
                    if (crc_q[j] && (pay_q[j] == pay_q[c])) begin
                        agree[c] = agree[c] + 3'd1;
                    end
                end
            end
        end

        all_eq = &crc_q;
        for (int unsigned c = 1; c < NCH; c++) begin
            if (pay_q[c] != pay_q[0]) all_eq = 1'b0;
        end

        // Lowest-index channel with a strict majority wins.
        maj_found = 1'b0;
        maj_pay   = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!maj_found && (agree[c] > 3'(NCH / 2))) begin
                maj_found = 1'b1;
                maj_pay   = pay_q[c];
            end
        end

        stat_d  = STAT_FAIL;
        voted_d = '0;
        map_d   = '1;
        if (all_eq) begin
            stat_d  = STAT_MATCH;
            voted_d = pay_q[0];
            map_d   = '0;
        end else if (maj_found) begin
            stat_d  = STAT_MAJORITY;
            voted_d = maj_pay;
            for (int unsigned c = 0; c < NCH; c++) begin
                map_d[c] = !crc_q[c] || (pay_q[c] != maj_pay);
            end
        end
    end

    // Result registers, loaded on COMP->RESULT and held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q  <= STAT_NONE;
            voted_q <= '0;
            map_q   <= '0;
        end else if (state_q == ST_COMP) begin
            stat_q  <= stat_d;
            voted_q <= voted_d;
            map_q   <= map_d;
        end
    end

    assign comp_status  = stat_q;
    assign voted_data   = voted_q;
    assign mismatch_map = map_q;

    // Reset shares the clear path so an aborted frame never bumps a counter.
    assign fail_inc = (state_q == ST_COMP) && (stat_d == STAT_FAIL);
    assign degr_inc = (state_q == ST_COMP) && (stat_d == STAT_MAJORITY);
    assign cnt_zero = rst || cnt_clr;

    sat_cnt #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .inc (fail_inc),
        .clr (cnt_zero),
        .cnt (fail_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_degr_cnt (
        .clk (clk),
        .inc (degr_inc),
        .clr (cnt_zero),
        .cnt (degr_cnt)
    );

endmodule

// File: tb/tb_multi_chan_comp.sv
module tb_multi_chan_comp;

    localparam int NCH     = 3;
    localparam int FRAME_W = 64;
    localparam int CRC_W   = 16;
    localparam int CNT_W   = 2;
    localparam int PAY_W   = FRAME_W - CRC_W;

    localparam logic [47:0] PA = 48'h123456789ABC;
    localparam logic [47:0] PB = 48'hCAFEF00D1234;
    localparam logic [47:0] PC = 48'h0F0F0F0F0F0F;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCH*FRAME_W-1:0] frame_in;
    logic [NCH-1:0]         crc_ok;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             comp_status;
    logic [PAY_W-1:0]       voted_data;
    logic [NCH-1:0]         mismatch_map;
    logic                   cnt_clr;
    logic [CNT_W-1:0]       fail_cnt;
    logic [CNT_W-1:0]       degr_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int m_fail = 0;
    int m_degr = 0;
    int sat_max = (1 << CNT_W) - 1;

    multi_chan_comp #(
        .NCH     (NCH),
        .FRAME_W (FRAME_W),
        .CRC_W   (CRC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_in     (frame_in),
        .crc_ok       (crc_ok),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .comp_status  (comp_status),
        .voted_data   (voted_data),
        .mismatch_map (mismatch_map),
        .cnt_clr      (cnt_clr),
        .fail_cnt     (fail_cnt),
        .degr_cnt     (degr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] p0, p1, p2;
        logic [2:0]  crc;
        logic [1:0]  st;
        logic [47:0] v;
        logic [2:0]  m;
        int          stall;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: majority voting straight from the rules, three channels.
    function automatic void model(input logic [47:0] p0, p1, p2, input logic [2:0] crc,
                                  output logic [1:0] st, output logic [47:0] v,
                                  output logic [2:0] m);
        logic [47:0] p [3];
        int votes;
        p[0] = p0; p[1] = p1; p[2] = p2;
        if (crc == 3'b111 && p0 == p1 && p1 == p2) begin
            st = 2'b00; v = p0; m = 3'b000;
            return;
        end
        for (int c = 0; c < 3; c++) begin
            if (crc[c]) begin
                votes = 0;
                for (int j = 0; j < 3; j++) if (crc[j] && p[j] == p[c]) votes++;
                if (votes >= 2) begin
                    st = 2'b10; v = p[c];
                    for (int j = 0; j < 3; j++) m[j] = !(crc[j] && p[j] == p[c]);
                    return;
                end
            end
        end
        st = 2'b01; v = '0; m = 3'b111;
    endfunction

    function automatic logic [NCH*FRAME_W-1:0] mk_frame(input logic [47:0] p0, p1, p2);
        logic [15:0] r0, r1, r2;
        r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom);
        return {p2, r2, p1, r1, p0, r0};
    endfunction

    // One full transaction. mode: 0 normal, 1 cnt_clr during COMP, 2 rst during COMP.
    task automatic do_frame(input string nm, input logic [47:0] p0, p1, p2,
                            input logic [2:0] crc, input int stall, input int mode);
        logic [1:0]  est;
        logic [47:0] ev;
        logic [2:0]  em;
        int          wait_cyc;
        model(p0, p1, p2, crc, est, ev, em);

        frame_in  = mk_frame(p0, p1, p2);
        crc_ok    = crc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_cyc  = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk({nm, ".ready"}, in_ready, 1);
        @(posedge clk); #1;                      // accept edge (cycle N)
        in_valid = 1'b0;
        frame_in = {6{32'($urandom)}};           // input may change freely in COMP
        crc_ok   = 3'($urandom);
        chk({nm, ".ov_n1"}, out_valid, 0);
        chk({nm, ".ir_comp"}, in_ready, 0);

        if (mode == 2) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            m_fail = 0; m_degr = 0;
            chk({nm, ".rst_status"}, comp_status, 2'b11);
            chk({nm, ".rst_ov"}, out_valid, 0);
            chk({nm, ".rst_ir"}, in_ready, 1);
            chk({nm, ".rst_fail"}, fail_cnt, 0);
            chk({nm, ".rst_degr"}, degr_cnt, 0);
            @(posedge clk); #1;
            chk({nm, ".rst_ov2"}, out_valid, 0);
            return;
        end

        if (mode == 1) cnt_clr = 1'b1;
        @(posedge clk); #1;                      // N+2: result visible
        cnt_clr = 1'b0;
        if (mode == 1) begin
            m_fail = 0; m_degr = 0;
        end else begin
            if (est == 2'b01 && m_fail < sat_max) m_fail++;
            if (est == 2'b10 && m_degr < sat_max) m_degr++;
        end
        chk({nm, ".ov_n2"}, out_valid, 1);
        chk({nm, ".status"}, comp_status, est);
        chk({nm, ".voted"}, voted_data, ev);
        chk({nm, ".map"}, mismatch_map, em);
        chk({nm, ".fail_cnt"}, fail_cnt, m_fail);
        chk({nm, ".degr_cnt"}, degr_cnt, m_degr);

        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_ov"}, out_valid, 1);
            chk({nm, ".hold_ir"}, in_ready, 0);
            chk({nm, ".hold_st"}, comp_status, est);
            chk({nm, ".hold_v"}, voted_data, ev);
            chk({nm, ".hold_m"}, mismatch_map, em);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".done_ov"}, out_valid, 0);
        chk({nm, ".done_ir"}, in_ready, 1);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{PA, PA, PA, 3'b111, 2'b00, PA,    3'b000, 0};
        vecs[1] = '{PA, PB, PA, 3'b111, 2'b10, PA,    3'b010, 5};
        vecs[2] = '{PA, PB, PC, 3'b111, 2'b01, 48'h0, 3'b111, 0};
        vecs[3] = '{PA, PB, PA, 3'b011, 2'b01, 48'h0, 3'b111, 1};
        vecs[4] = '{PA, PA, PB, 3'b011, 2'b10, PA,    3'b100, 0};
        vecs[5] = '{PB, PA, PA, 3'b110, 2'b10, PA,    3'b001, 2};
        vecs[6] = '{PA, PA, PA, 3'b101, 2'b10, PA,    3'b010, 0};
        vecs[7] = '{PA, PA, PA, 3'b000, 2'b01, 48'h0, 3'b111, 0};
        vecs[8] = '{PB, PA, PA, 3'b111, 2'b10, PA,    3'b001, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        crc_ok = '0; frame_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.status", comp_status, 2'b11);
        chk("reset.ov", out_valid, 0);
        chk("reset.ir", in_ready, 1);
        chk("reset.voted", voted_data, 0);
        chk("reset.map", mismatch_map, 0);
        chk("reset.fail", fail_cnt, 0);
        chk("reset.degr", degr_cnt, 0);

        // Table: expected values are hand-derived; also cross-check the model.
        for (int i = 0; i < 9; i++) begin
            logic [1:0]  mst;
            logic [47:0] mv;
            logic [2:0]  mm;
            model(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].crc, mst, mv, mm);
            chk($sformatf("vec%0d.model_st", i), mst, vecs[i].st);
            chk($sformatf("vec%0d.model_v", i), mv, vecs[i].v);
            chk($sformatf("vec%0d.model_m", i), mm, vecs[i].m);
            do_frame($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1, vecs[i].p2,
                     vecs[i].crc, vecs[i].stall, 0);
        end

        // Counter clear while idle
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        m_fail = 0; m_degr = 0;
        chk("clr.fail", fail_cnt, 0);
        chk("clr.degr", degr_cnt, 0);

        // Four FAILs saturate a 2-bit counter at 3
        for (int i = 0; i < 4; i++) do_frame($sformatf("sat%0d", i), PA, PB, PC, 3'b111, 0, 0);
        chk("sat.fail_is_3", fail_cnt, 3);

        // cnt_clr coincident with a FAIL increment leaves 0
        do_frame("clr_fail", PA, PB, PC, 3'b111, 0, 1);
        chk("clr_fail.zero", fail_cnt, 0);

        // Degraded result then reset during COMP
        do_frame("pre_rst", PA, PB, PA, 3'b111, 0, 0);
        do_frame("rst_comp", PA, PB, PC, 3'b111, 0, 2);
        do_frame("post_rst", PA, PA, PA, 3'b111, 0, 0);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [47:0] pool [4];
            logic [47:0] q0, q1, q2;
            pool[0] = PA; pool[1] = PB; pool[2] = PC;
            pool[3] = {16'($urandom), 32'($urandom)};
            q0 = pool[$urandom_range(0, 3)];
            q1 = pool[$urandom_range(0, 3)];
            q2 = pool[$urandom_range(0, 3)];
            do_frame($sformatf("rnd%0d", i), q0, q1, q2, 3'($urandom),
                     int'($urandom_range(0, 3)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
